ticket_seq_ctrl: RTL and testbench

Sequencer for the ticket vending machine that owns the coin-summing unit. It latches a ticket request and its price, then accepts coins from the acceptor one at a time. Each coin is fed to the summing unit with its first-flag/ready/data handshake, and the returned total is compared against the price. The block then dispenses the ticket with change, refunds on cancel or timeout, and flags a hung summing unit.

---
 rtl/ticket_seq_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_ticket_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ticket_seq_ctrl.sv
// Ticket vending sequencer: latches a request, feeds coins to the summing unit, dispenses or refunds.
// Optional build macro TKT_CTRL_SHADOW_CHECK_EN cross-checks the returned total against a local shadow sum.
module ticket_seq_ctrl #(
  parameter int unsigned PRICE0       = 5,
  parameter int unsigned PRICE1       = 10,
  parameter int unsigned PRICE2       = 15,
  parameter int unsigned PRICE3       = 20,
  parameter int unsigned MAX_CREDIT   = 60,
  parameter int unsigned COIN_TIMEOUT = 1000,
  parameter int unsigned SUM_WAIT_MAX = 15,
  parameter int unsigned TMR_W        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tkt_req,
  input  logic [1:0] tkt_sel,
  input  logic       coin_valid,
  input  logic [1:0] coin_code,
  input  logic       cancel,
  output logic       sum_frt,
  output logic       sum_in_rdy,
  output logic [7:0] sum_data,
  input  logic       sum_out_rdy,
  input  logic [7:0] sum_total,
  output logic       busy,
  output logic       coin_ack,
  output logic       coin_rej,
  output logic       tkt_out,
  output logic [1:0] tkt_id,
  output logic       chg_valid,
  output logic [7:0] chg_amt,
  output logic       refund,
  output logic       err
);

  localparam int unsigned DW = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_COIN, S_SEND_RDY, S_SEND_DATA, S_WAIT_SUM,
    S_CHECK, S_DISPENSE, S_REFUND, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     price_q, credit_q, shadow_q, value_q;
  logic [1:0]        sel_q;
  logic [TMR_W-1:0]  timer_q;
  logic              first_q;

  logic              sum_frt_d, sum_in_rdy_d, busy_d, coin_ack_d, coin_rej_d;
  logic              tkt_out_d, chg_valid_d, refund_d, err_d;
  logic [DW-1:0]     sum_data_d, chg_amt_d;
  logic [1:0]        tkt_id_d;

  logic [DW-1:0]     coin_val_c;
  logic              coin_bad_c, coin_timeout_c, sum_timeout_c;

  function automatic logic [DW-1:0] price_of(input logic [1:0] sel);
    case (sel)
      2'd0:    price_of = DW'(PRICE0);
      2'd1:    price_of = DW'(PRICE1);
      2'd2:    price_of = DW'(PRICE2);
      default: price_of = DW'(PRICE3);
    endcase
  endfunction

  // Coin decode and acceptance limit (9-bit sum so the limit compare cannot wrap)
  always_comb begin
    coin_val_c = '0;
    case (coin_code)
      2'b00:   coin_val_c = DW'(1);
      2'b01:   coin_val_c = DW'(5);
      2'b10:   coin_val_c = DW'(10);
      default: coin_val_c = '0;
    endcase
    coin_bad_c = (coin_code == 2'b11) ||
                 (({1'b0, shadow_q} + {1'b0, coin_val_c}) > (DW+1)'(MAX_CREDIT));
    coin_timeout_c = (timer_q == TMR_W'(COIN_TIMEOUT - 1));
    sum_timeout_c  = (timer_q == TMR_W'(SUM_WAIT_MAX - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (tkt_req) state_d = S_WAIT_COIN;
      S_WAIT_COIN: begin
        if (cancel || coin_timeout_c)       state_d = (shadow_q != '0) ? S_REFUND : S_IDLE;
        else if (coin_valid && !coin_bad_c) state_d = S_SEND_RDY;
      end
      S_SEND_RDY:  state_d = S_SEND_DATA;
      S_SEND_DATA: state_d = S_WAIT_SUM;
      S_WAIT_SUM: begin
        if (sum_out_rdy)        state_d = S_CHECK;
        else if (sum_timeout_c) state_d = S_ERROR;
      end
      S_CHECK: begin
`ifdef TKT_CTRL_SHADOW_CHECK_EN
        if (credit_q != shadow_q)     state_d = S_ERROR;
        else if (credit_q >= price_q) state_d = S_DISPENSE;
        else                          state_d = S_WAIT_COIN;
`else
        if (credit_q >= price_q) state_d = S_DISPENSE;
        else                     state_d = S_WAIT_COIN;
`endif
      end
      S_DISPENSE:  state_d = S_IDLE;
      S_REFUND:    state_d = S_IDLE;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode for the next cycle; registered below
  always_comb begin
    sum_frt_d    = 1'b0;
    sum_in_rdy_d = 1'b0;
    sum_data_d   = '0;
    busy_d       = (state_d != S_IDLE);
    coin_ack_d   = (state_q == S_WAIT_COIN) && (state_d == S_SEND_RDY);
    coin_rej_d   = coin_valid && !coin_ack_d;
    tkt_out_d    = 1'b0;
    tkt_id_d     = '0;
    chg_valid_d  = 1'b0;
    chg_amt_d    = '0;
    refund_d     = 1'b0;
    err_d        = (state_d == S_ERROR);
    case (state_d)
      S_SEND_RDY: begin
        sum_in_rdy_d = 1'b1;
        sum_frt_d    = first_q;
      end
      S_SEND_DATA: sum_data_d = value_q;
      S_DISPENSE: begin
        tkt_out_d = 1'b1;
        tkt_id_d  = sel_q;
        if (credit_q > price_q) begin
          chg_valid_d = 1'b1;
          chg_amt_d   = credit_q - price_q;
        end
      end
      S_REFUND: begin
        chg_valid_d = 1'b1;
        refund_d    = 1'b1;
        chg_amt_d   = (credit_q != '0) ? credit_q : shadow_q;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_frt    <= 1'b0;
      sum_in_rdy <= 1'b0;
      sum_data   <= '0;
      busy       <= 1'b0;
      coin_ack   <= 1'b0;
      coin_rej   <= 1'b0;
      tkt_out    <= 1'b0;
      tkt_id     <= '0;
      chg_valid  <= 1'b0;
      chg_amt    <= '0;
      refund     <= 1'b0;
      err        <= 1'b0;
    end else begin
      sum_frt    <= sum_frt_d;
      sum_in_rdy <= sum_in_rdy_d;
      sum_data   <= sum_data_d;
      busy       <= busy_d;
      coin_ack   <= coin_ack_d;
      coin_rej   <= coin_rej_d;
      tkt_out    <= tkt_out_d;
      tkt_id     <= tkt_id_d;
      chg_valid  <= chg_valid_d;
      chg_amt    <= chg_amt_d;
      refund     <= refund_d;
      err        <= err_d;
    end
  end

  // Transaction datapath; the timer is shared between coin wait and sum wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      price_q  <= '0;
      sel_q    <= '0;
      credit_q <= '0;
      shadow_q <= '0;
      value_q  <= '0;
      timer_q  <= '0;
      first_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (tkt_req) begin
          price_q  <= price_of(tkt_sel);
          sel_q    <= tkt_sel;
          credit_q <= '0;
          shadow_q <= '0;
          first_q  <= 1'b1;
          timer_q  <= '0;
        end
        S_WAIT_COIN: begin
          timer_q <= timer_q + TMR_W'(1);
          if (state_d == S_SEND_RDY) value_q <= coin_val_c;
        end
        S_SEND_DATA: begin
          first_q <= 1'b0;
          timer_q <= '0;
        end
        S_WAIT_SUM: begin
          timer_q <= timer_q + TMR_W'(1);
          if (sum_out_rdy) begin
            credit_q <= sum_total;
            shadow_q <= shadow_q + value_q;
          end
        end
        S_CHECK: if (state_d == S_WAIT_COIN) timer_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ticket_seq_ctrl.sv
// Directed bench for ticket_seq_ctrl: default instance plus a MAX_CREDIT=12 instance on shared stimulus.
module tb_ticket_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tkt_req, coin_valid, cancel, sum_out_rdy;
  logic [1:0] tkt_sel, coin_code;
  logic [7:0] sum_total;

  logic       a_sum_frt, a_sum_in_rdy, a_busy, a_coin_ack, a_coin_rej, a_tkt_out;
  logic       a_chg_valid, a_refund, a_err;
  logic [7:0] a_sum_data, a_chg_amt;
  logic [1:0] a_tkt_id;
  logic       b_sum_frt, b_sum_in_rdy, b_busy, b_coin_ack, b_coin_rej, b_tkt_out;
  logic       b_chg_valid, b_refund, b_err;
  logic [7:0] b_sum_data, b_chg_amt;
  logic [1:0] b_tkt_id;

  int total = 0;
  int bad   = 0;

  ticket_seq_ctrl ua (
    .clk(clk), .rst(rst), .tkt_req(tkt_req), .tkt_sel(tkt_sel),
    .coin_valid(coin_valid), .coin_code(coin_code), .cancel(cancel),
    .sum_frt(a_sum_frt), .sum_in_rdy(a_sum_in_rdy), .sum_data(a_sum_data),
    .sum_out_rdy(sum_out_rdy), .sum_total(sum_total), .busy(a_busy),
    .coin_ack(a_coin_ack), .coin_rej(a_coin_rej), .tkt_out(a_tkt_out),
    .tkt_id(a_tkt_id), .chg_valid(a_chg_valid), .chg_amt(a_chg_amt),
    .refund(a_refund), .err(a_err)
  );

  ticket_seq_ctrl #(.MAX_CREDIT(12)) ub (
    .clk(clk), .rst(rst), .tkt_req(tkt_req), .tkt_sel(tkt_sel),
    .coin_valid(coin_valid), .coin_code(coin_code), .cancel(cancel),
    .sum_frt(b_sum_frt), .sum_in_rdy(b_sum_in_rdy), .sum_data(b_sum_data),
    .sum_out_rdy(sum_out_rdy), .sum_total(sum_total), .busy(b_busy),
    .coin_ack(b_coin_ack), .coin_rej(b_coin_rej), .tkt_out(b_tkt_out),
    .tkt_id(b_tkt_id), .chg_valid(b_chg_valid), .chg_amt(b_chg_amt),
    .refund(b_refund), .err(b_err)
  );

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] s);
    tkt_sel = s;
    tkt_req = 1'b1;
    clk1();
    tkt_req = 1'b0;
    chk("busy_after_req", 32'(a_busy), 1);
  endtask

  task automatic coin_in(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_code  = code;
    clk1();
    coin_valid = 1'b0;
    coin_code  = 2'b00;
  endtask

  // Accepted coin, then the summing unit answers; leaves the DUT in CHECK
  task automatic pay(input logic [1:0] code, input logic [7:0] val, input logic frt,
                     input logic [7:0] tot);
    coin_in(code);
    chk("coin_ack",     32'(a_coin_ack),   1);
    chk("in_rdy_n1",    32'(a_sum_in_rdy), 1);
    chk("frt_n1",       32'(a_sum_frt),    32'(frt));
    chk("data_zero_n1", 32'(a_sum_data),   0);
    clk1();
    chk("data_n2",      32'(a_sum_data),   32'(val));
    chk("in_rdy_n2",    32'(a_sum_in_rdy), 0);
    clk1();
    sum_out_rdy = 1'b1;
    sum_total   = tot;
    clk1();
    sum_out_rdy = 1'b0;
    sum_total   = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst = 1'b1; tkt_req = 1'b0; tkt_sel = 2'd0; coin_valid = 1'b0; coin_code = 2'd0;
    cancel = 1'b0; sum_out_rdy = 1'b0; sum_total = 8'd0;
    clk1(); clk1();
    chk("rst_a_outs", 32'({a_sum_frt, a_sum_in_rdy, a_sum_data, a_busy, a_coin_ack, a_coin_rej,
                           a_tkt_out, a_tkt_id, a_chg_valid, a_chg_amt, a_refund, a_err}), 0);
    chk("rst_b_outs", 32'({b_sum_frt, b_sum_in_rdy, b_sum_data, b_busy, b_coin_ack, b_coin_rej,
                           b_tkt_out, b_tkt_id, b_chg_valid, b_chg_amt, b_refund, b_err}), 0);
    rst = 1'b0;
    clk1();
    chk("idle_busy", 32'(a_busy), 0);

    // Type 1 (10): coin 1 then coin 10, summer returns 1 then 11 -> change 1
    start(2'd1);
    pay(2'b00, 8'd1, 1'b1, 8'd1);
    clk1();
    chk("t1_no_disp_yet", 32'(a_tkt_out), 0);
    pay(2'b10, 8'd10, 1'b0, 8'd11);
    clk1();
    chk("t1_tkt_out",   32'(a_tkt_out),   1);
    chk("t1_tkt_id",    32'(a_tkt_id),    1);
    chk("t1_chg_valid", 32'(a_chg_valid), 1);
    chk("t1_chg_amt",   32'(a_chg_amt),   1);
    chk("t1_refund",    32'(a_refund),    0);
    clk1();
    chk("t1_idle", 32'(a_busy), 0);
    chk("t1_pulse_end", 32'(a_tkt_out), 0);

    // Type 0 (5): exact payment with one 5 coin
    start(2'd0);
    pay(2'b01, 8'd5, 1'b1, 8'd5);
    clk1();
    chk("t0_tkt_out",   32'(a_tkt_out),   1);
    chk("t0_tkt_id",    32'(a_tkt_id),    0);
    chk("t0_chg_valid", 32'(a_chg_valid), 0);
    clk1();
    chk("t0_idle", 32'(a_busy), 0);

    // Type 3 (20): coin 5, invalid code, then cancel with a coincident coin
    start(2'd3);
    pay(2'b01, 8'd5, 1'b1, 8'd5);
    clk1();
    chk("t3_wait_busy", 32'(a_busy), 1);
    coin_in(2'b11);
    chk("t3_inv_rej", 32'(a_coin_rej),   1);
    chk("t3_inv_ack", 32'(a_coin_ack),   0);
    chk("t3_inv_rdy", 32'(a_sum_in_rdy), 0);
    cancel = 1'b1; coin_valid = 1'b1; coin_code = 2'b01;
    clk1();
    cancel = 1'b0; coin_valid = 1'b0; coin_code = 2'b00;
    chk("t3_cxl_rej",   32'(a_coin_rej),  1);
    chk("t3_cxl_ack",   32'(a_coin_ack),  0);
    chk("t3_chg_valid", 32'(a_chg_valid), 1);
    chk("t3_refund",    32'(a_refund),    1);
    chk("t3_chg_amt",   32'(a_chg_amt),   5);
    chk("t3_no_tkt",    32'(a_tkt_out),   0);
    clk1();
    chk("t3_idle", 32'(a_busy), 0);
    chk("t3_chg_end", 32'(a_chg_valid), 0);

    // Summer reports 7 for a coin of 5
    start(2'd0);
    pay(2'b01, 8'd5, 1'b1, 8'd7);
    clk1();
`ifdef TKT_CTRL_SHADOW_CHECK_EN
    chk("sh_err",     32'(a_err),     1);
    chk("sh_no_tkt",  32'(a_tkt_out), 0);
`else
    chk("sh_tkt_out", 32'(a_tkt_out), 1);
    chk("sh_chg_amt", 32'(a_chg_amt), 2);
`endif
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    clk1();
    chk("rst2_err",  32'(a_err),  0);
    chk("rst2_busy", 32'(a_busy), 0);

    // Limit 12 on ub: 10 then 5 rejected, then coin timeout refunds 10.
    // ua accepts the 5 but its summer never answers -> sum-wait error.
    start(2'd3);
    pay(2'b10, 8'd10, 1'b1, 8'd10);
    clk1();
    coin_in(2'b01);
    chk("lim_b_rej", 32'(b_coin_rej), 1);
    chk("lim_b_ack", 32'(b_coin_ack), 0);
    chk("lim_a_ack", 32'(a_coin_ack), 1);
    waited = 0;
    while (!b_chg_valid && waited < 1100) begin
      clk1();
      waited++;
      if (waited == 16) chk("sumto_a_err_pre", 32'(a_err), 0);
      if (waited == 17) chk("sumto_a_err",     32'(a_err), 1);
    end
    chk("to_b_wait",   32'(waited),      999);
    chk("to_b_chg",    32'(b_chg_valid), 1);
    chk("to_b_refund", 32'(b_refund),    1);
    chk("to_b_amt",    32'(b_chg_amt),   10);
    chk("err_a_busy",  32'(a_busy),      1);
    chk("err_a_strb",  32'({a_sum_in_rdy, a_tkt_out, a_chg_valid}), 0);
    coin_in(2'b00);
    chk("err_a_rej",    32'(a_coin_rej), 1);
    chk("err_a_sticky", 32'(a_err),      1);
    chk("to_b_idle",    32'(b_busy),     0);

    rst = 1'b1;
    #1;
    chk("async_rst_err", 32'(a_err), 0);
    clk1();
    rst = 1'b0;
    clk1();
    chk("final_busy", 32'(a_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
